// File: rtl/pmem_responder.sv
// rtl/pmem_responder.sv - load/store memory responder with configurable latency
// Optional access-error checking is enabled by defining PMEM_ERR_EN.
module pmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h80000000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [7:0]  req_wmask,
  input  logic [1:0]  req_size,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

`ifdef PMEM_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [4:0]    sh;
  logic [7:0]    mask_wide;
  logic [3:0]    eff_mask;
  logic [31:0]   eff_data;
  logic [31:0]   word_rd;
  logic [31:0]   shifted;
  logic [31:0]   load_data;
  logic          range_err;
  logic          align_err;
  logic          acc_err;
  logic          commit;
  logic          do_write;
  logic          unused_off;

  // Datapath works from the latched request so it is stable across WAIT.
  always_comb begin
    offset    = addr_q - BASE_ADDR;
    idx       = offset[AW+1:2];
    lane      = addr_q[1:0];
    sh        = {lane, 3'b000};
    mask_wide = {4'b0000, wmask_q} << lane;
    eff_mask  = mask_wide[3:0];
    eff_data  = wdata_q << sh;
    word_rd   = mem[idx];
    shifted   = word_rd >> sh;
    case (size_q)
      2'd0:    load_data = {24'b0, shifted[7:0]};
      2'd1:    load_data = {16'b0, shifted[15:0]};
      default: load_data = shifted;
    endcase
    range_err = (offset[31:AW+2] != '0);
    if (wen_q) begin
      align_err = (mask_wide[7:4] != 4'b0000);
    end else begin
      align_err = (size_q[1] && (lane != 2'd0)) || ((size_q == 2'd1) && (lane == 2'd3));
    end
    acc_err  = ERR_EN & (range_err | align_err);
    commit   = (state_q == WAIT) && (cnt_q == 4'd0);
    do_write = commit & wen_q & ~acc_err & ~reset;
  end

  assign unused_off = ^offset[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wmask_d = req_wmask[3:0];
          size_d  = req_size;
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Counter hits zero one cycle before RESP, so RESP lands LATENCY edges after accept.
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          rdata_d = (wen_q || acc_err) ? 32'd0 : load_data;
          err_d   = acc_err;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wen_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wmask_q <= 4'd0;
      size_q  <= 2'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // The array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (eff_mask[b]) begin
          mem[idx][8*b +: 8] <= eff_data[8*b +: 8];
        end
      end
    end
  end

  assign req_ready  = (state_q == IDLE) & ~reset;
  assign resp_valid = (state_q == RESP) & ~reset;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_pmem_responder.sv
// tb/tb_pmem_responder.sv - scoreboard bench for pmem_responder
// Expectations for error cases depend on whether PMEM_ERR_EN is defined.
module tb_pmem_responder;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [7:0]  req_wmask = 8'd0;
  logic [1:0]  req_size = 2'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb[$];
  bit   seen = 1'b0;

  pmem_responder #(
    .DEPTH_WORDS(1024),
    .BASE_ADDR(32'h80000000),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_wen(req_wen),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_wmask(req_wmask),
    .req_size(req_size),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && resp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", {31'd0, resp_valid}, 32'd0);
      end else begin
        if (!seen) begin
          check({sb[0].name, "_latency"}, cyc - sb[0].acc, LAT);
          seen = 1'b1;
        end
        if (resp_ready) begin
          e = sb.pop_front();
          check({e.name, "_rdata"}, resp_rdata, e.rdata);
          check({e.name, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
          seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input string name, input bit wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [7:0] wmask, input logic [1:0] size,
                       input logic [31:0] exp_rdata, input bit exp_err, input bit want);
    bit ok;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    req_size  = size;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check({name, "_accept"}, {31'd0, req_ready}, 32'd1);
    end else if (want) begin
      sb.push_back('{name: name, rdata: exp_rdata, err: exp_err, acc: cyc + 1});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) check("drain_timeout", sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;

    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'd0, resp_err}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;

    issue("st_word", 1, 32'h80000010, 32'hDEADBEEF, 8'h0F, 2'd2, 32'h0, 0, 1);
    issue("ld_word", 0, 32'h80000010, 32'h0, 8'h00, 2'd2, 32'hDEADBEEF, 0, 1);
    issue("st_byte", 1, 32'h80000013, 32'h000000AA, 8'h01, 2'd0, 32'h0, 0, 1);
    issue("ld_word2", 0, 32'h80000010, 32'h0, 8'h00, 2'd2, 32'hAAADBEEF, 0, 1);
    issue("ld_byte", 0, 32'h80000013, 32'h0, 8'h00, 2'd0, 32'h000000AA, 0, 1);
    issue("ld_half", 0, 32'h80000012, 32'h0, 8'h00, 2'd1, 32'h0000AAAD, 0, 1);
    issue("st_clr20", 1, 32'h80000020, 32'h0, 8'hFF, 2'd2, 32'h0, 0, 1);
    issue("st_half21", 1, 32'h80000021, 32'h0000CC55, 8'hF3, 2'd1, 32'h0, 0, 1);
    issue("ld_word20", 0, 32'h80000020, 32'h0, 8'h00, 2'd3, 32'h00CC5500, 0, 1);
    issue("ld_byte22", 0, 32'h80000022, 32'h0, 8'h00, 2'd0, 32'h000000CC, 0, 1);
`ifdef PMEM_ERR_EN
    issue("st_lost", 1, 32'h80000023, 32'h0000FFFF, 8'h03, 2'd1, 32'h0, 1, 1);
    issue("ld_after_lost", 0, 32'h80000020, 32'h0, 8'h00, 2'd2, 32'h00CC5500, 0, 1);
`else
    issue("st_lost", 1, 32'h80000023, 32'h0000FFFF, 8'h03, 2'd1, 32'h0, 0, 1);
    issue("ld_after_lost", 0, 32'h80000020, 32'h0, 8'h00, 2'd2, 32'hFFCC5500, 0, 1);
`endif

    wait_drain();
    resp_ready = 1'b0;
    issue("hold_ld", 0, 32'h80000010, 32'h0, 8'h00, 2'd2, 32'hAAADBEEF, 0, 1);
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("hold_wait_valid", {31'd0, resp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_rdata", resp_rdata, 32'hAAADBEEF);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("hs_req_ready", {31'd0, req_ready}, 32'd1);
    check("hs_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    #1;

    issue("rst_st", 1, 32'h80000010, 32'h12345678, 8'h0F, 2'd2, 32'h0, 0, 0);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("wait_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("wait_rst_req_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("wait_rst_release_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    issue("ld_after_rst", 0, 32'h80000010, 32'h0, 8'h00, 2'd2, 32'hAAADBEEF, 0, 1);

    issue("st_word0", 1, 32'h80000000, 32'h0BADF00D, 8'h0F, 2'd2, 32'h0, 0, 1);
`ifdef PMEM_ERR_EN
    issue("ld_oor", 0, 32'h80001000, 32'h0, 8'h00, 2'd2, 32'h0, 1, 1);
    issue("ld_misal", 0, 32'h80000011, 32'h0, 8'h00, 2'd2, 32'h0, 1, 1);
`else
    issue("ld_oor", 0, 32'h80001000, 32'h0, 8'h00, 2'd2, 32'h0BADF00D, 0, 1);
    issue("ld_misal", 0, 32'h80000011, 32'h0, 8'h00, 2'd2, 32'h00AAADBE, 0, 1);
`endif

    wait_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
